apb_master_arbiter: RTL and testbench

APB master controller that shares the peripheral APB bus between two requesters (CPU load/store port, DMA port). Arbitrates round-robin, decodes the address to one of four slave selects (GPO, GPI, GPIO, UART slots), sequences the APB IDLE/SETUP/ACCESS phases, and muxes slave read data and ready back to the granted requester. Adds decode-error and ready-timeout protection so a hung or absent slave cannot stall the core.

---
 rtl/apb_master_arbiter_if.sv | 56 +++++
 rtl/apb_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter_if
//  Brief    : Requester ports (CPU, DMA) and APB bus signals of the
//             two-port APB master arbiter, grouped with modports.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_master_arbiter_if;
    // Requester 0 (CPU load/store port)
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req0_write;
    logic [31:0] req0_wdata;
    logic        req0_done;
    logic        req0_err;
    logic [31:0] req0_rdata;
    // Requester 1 (DMA port)
    logic        req1_valid;
    logic [31:0] req1_addr;
    logic        req1_write;
    logic [31:0] req1_wdata;
    logic        req1_done;
    logic        req1_err;
    logic [31:0] req1_rdata;
    // APB bus
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    // Arbiter side
    modport master (
        input  req0_valid, req0_addr, req0_write, req0_wdata,
        output req0_done, req0_err, req0_rdata,
        input  req1_valid, req1_addr, req1_write, req1_wdata,
        output req1_done, req1_err, req1_rdata,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    // Requesters and slaves side
    modport slave (
        output req0_valid, req0_addr, req0_write, req0_wdata,
        input  req0_done, req0_err, req0_rdata,
        output req1_valid, req1_addr, req1_write, req1_wdata,
        input  req1_done, req1_err, req1_rdata,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter
//  Brief    : Two-requester round-robin APB master with address decode to
//             four slave selects, decode-error and PREADY-timeout protection.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int          TIMEOUT = 16,
    parameter logic [15:0] BASE_HI = 16'h1000
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_arbiter_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Last wait-counter value before the access is abandoned
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        last_grant_q;
    logic        gnt_q;
    logic [1:0]  slv_q;
    logic        err_q;
    logic [7:0]  wait_q;
    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic        w_any_req;
    logic        w_gnt;
    logic [31:0] w_addr;
    logic        w_write;
    logic [31:0] w_wdata;
    logic        w_addr_ok;
    logic        w_sel_ready;
    logic [31:0] w_sel_rdata;
    logic        w_tmo;

    // Arbitration, address decode and selected-slave response mux
    always_comb begin
        w_any_req = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = ~last_grant_q;          // tie: the port not served last
        end else begin
            w_gnt = ~bus.req0_valid;        // single requester, or don't-care
        end
        w_addr    = w_gnt ? bus.req1_addr  : bus.req0_addr;
        w_write   = w_gnt ? bus.req1_write : bus.req0_write;
        w_wdata   = w_gnt ? bus.req1_wdata : bus.req0_wdata;
        w_addr_ok = (w_addr[31:16] == BASE_HI) && (w_addr[15:14] == 2'b00);
        case (slv_q)
            2'd0:    begin w_sel_ready = bus.PREADY0; w_sel_rdata = bus.PRDATA0; end
            2'd1:    begin w_sel_ready = bus.PREADY1; w_sel_rdata = bus.PRDATA1; end
            2'd2:    begin w_sel_ready = bus.PREADY2; w_sel_rdata = bus.PRDATA2; end
            default: begin w_sel_ready = bus.PREADY3; w_sel_rdata = bus.PRDATA3; end
        endcase
        w_tmo = (wait_q == C_WAIT_LAST);
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    state_d = w_addr_ok ? S_SETUP : S_RESP;
                end
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (w_sel_ready || w_tmo) begin
                    state_d = S_RESP;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Transfer datapath: request latch, wait counter, response capture
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            slv_q        <= 2'd0;
            err_q        <= 1'b0;
            wait_q       <= 8'd0;
            paddr_q      <= 32'd0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any_req) begin
                        paddr_q  <= w_addr;
                        pwrite_q <= w_write;
                        pwdata_q <= w_wdata;
                        gnt_q    <= w_gnt;
                        slv_q    <= w_addr[13:12];
                        err_q    <= ~w_addr_ok;
                        wait_q   <= 8'd0;
                    end
                end
                S_ACCESS: begin
                    if (w_sel_ready) begin
                        err_q <= 1'b0;
                        if (!pwrite_q) begin
                            if (gnt_q) begin
                                rdata1_q <= w_sel_rdata;
                            end else begin
                                rdata0_q <= w_sel_rdata;
                            end
                        end
                    end else if (w_tmo) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_RESP:  last_grant_q <= gnt_q;
                default: ;
            endcase
        end
    end

    // Bus and requester outputs decoded from state
    always_comb begin
        bus.PADDR      = paddr_q;
        bus.PWRITE     = pwrite_q;
        bus.PWDATA     = pwdata_q;
        bus.PSEL       = ((state_q == S_SETUP) || (state_q == S_ACCESS))
                         ? (4'b0001 << slv_q) : 4'b0000;
        bus.PENABLE    = (state_q == S_ACCESS);
        bus.req0_done  = (state_q == S_RESP) && !gnt_q;
        bus.req1_done  = (state_q == S_RESP) &&  gnt_q;
        bus.req0_err   = bus.req0_done && err_q;
        bus.req1_err   = bus.req1_done && err_q;
        bus.req0_rdata = rdata0_q;
        bus.req1_rdata = rdata1_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_arbiter
//  Brief    : Directed bench for apb_master_arbiter with a transaction-level
//             reference model and per-cycle output comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int TMO = 16;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;

    apb_master_arbiter_if bus();

    apb_master_arbiter #(.TIMEOUT(TMO), .BASE_HI(16'h1000)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- slave responders ----------------
    int          s_wait [4];   // ACCESS cycles before PREADY; large = never
    logic [31:0] s_data [4];
    int          s_cnt  [4];
    logic        noise_en = 1'b0;
    logic        noise0   = 1'b0;
    logic [3:0]  w_rdy;

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            w_rdy[s] = bus.PSEL[s] & bus.PENABLE & (s_cnt[s] == s_wait[s]);
        end
        bus.PREADY0 = w_rdy[0] | noise0;
        bus.PREADY1 = w_rdy[1];
        bus.PREADY2 = w_rdy[2];
        bus.PREADY3 = w_rdy[3];
        bus.PRDATA0 = s_data[0];
        bus.PRDATA1 = s_data[1];
        bus.PRDATA2 = s_data[2];
        bus.PRDATA3 = s_data[3];
    end

    always @(posedge PCLK) begin
        for (int s = 0; s < 4; s++) begin
            s_cnt[s] <= (bus.PSEL[s] & bus.PENABLE) ? s_cnt[s] + 1 : 0;
        end
    end

    always @(negedge PCLK) begin
        noise0 <= noise_en ? ~noise0 : 1'b0;
    end

    // ---------------- transaction-level reference model ----------------
    bit          act;
    int          tg, tn, tD, tport;
    bit          tok, terr;
    logic [1:0]  tslv;
    logic [31:0] base_rd [2];
    bit          upd_en;
    logic [31:0] upd_val;
    bit          last_g;
    logic [31:0] e_paddr, e_pwdata;
    logic        e_pwrite;

    function automatic void model_reset();
        act        = 0;
        upd_en     = 0;
        base_rd[0] = '0;
        base_rd[1] = '0;
        last_g     = 1;
        e_paddr    = '0;
        e_pwdata   = '0;
        e_pwrite   = 1'b0;
    endfunction

    initial begin
        logic [31:0] a;
        logic        w;
        forever begin
            @(posedge PCLK);
            if (!PRESET) begin
                model_reset();
            end else if (!act || cyc > tD) begin
                if (bus.req0_valid || bus.req1_valid) begin
                    if (act && upd_en) base_rd[tport] = upd_val;
                    upd_en = 0;
                    if (bus.req0_valid && bus.req1_valid) tport = last_g ? 0 : 1;
                    else                                   tport = bus.req0_valid ? 0 : 1;
                    last_g   = (tport == 1);
                    a        = tport ? bus.req1_addr  : bus.req0_addr;
                    w        = tport ? bus.req1_write : bus.req0_write;
                    e_paddr  = a;
                    e_pwrite = w;
                    e_pwdata = tport ? bus.req1_wdata : bus.req0_wdata;
                    tok      = (a[31:16] == 16'h1000) && (a[15:14] == 2'b00);
                    tslv     = a[13:12];
                    tg       = cyc;
                    act      = 1;
                    if (!tok) begin
                        terr = 1; tn = 0; tD = tg + 1;
                    end else begin
                        if (s_wait[tslv] + 1 <= TMO) begin
                            tn = s_wait[tslv] + 1; terr = 0;
                            if (!w) begin upd_en = 1; upd_val = s_data[tslv]; end
                        end else begin
                            tn = TMO; terr = 1;
                        end
                        tD = tg + 2 + tn;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int   done_cnt [2] = '{0, 0};
    int   done_cyc [2];
    logic done_err [2];
    int   order [$];
    int   psel_hi = 0;
    int   pen_hi  = 0;

    initial begin
        logic [3:0]  ep;
        logic        een, d0, d1, e0, e1;
        logic [31:0] r0, r1;
        forever begin
            @(negedge PCLK);
            if (!PRESET) begin
                ep = 4'b0; een = 0; d0 = 0; d1 = 0; e0 = 0; e1 = 0; r0 = '0; r1 = '0;
                chk("rst_PADDR",  bus.PADDR,  32'd0);
                chk("rst_PWRITE", bus.PWRITE, 32'd0);
                chk("rst_PWDATA", bus.PWDATA, 32'd0);
            end else begin
                ep = 4'b0; een = 0; d0 = 0; d1 = 0; e0 = 0; e1 = 0;
                r0 = base_rd[0]; r1 = base_rd[1];
                if (act) begin
                    if (tok && cyc >= tg + 1 && cyc <= tg + 1 + tn) ep = 4'b0001 << tslv;
                    een = tok && cyc >= tg + 2 && cyc <= tg + 1 + tn;
                    if (cyc == tD) begin
                        if (tport == 0) begin d0 = 1; e0 = terr; end
                        else            begin d1 = 1; e1 = terr; end
                    end
                    if (upd_en && cyc >= tD) begin
                        if (tport == 0) r0 = upd_val; else r1 = upd_val;
                    end
                end
                chk("PADDR",  bus.PADDR,  e_paddr);
                chk("PWRITE", bus.PWRITE, e_pwrite);
                chk("PWDATA", bus.PWDATA, e_pwdata);
                if (bus.req0_done) begin done_cnt[0]++; done_cyc[0] = cyc; done_err[0] = bus.req0_err; order.push_back(0); end
                if (bus.req1_done) begin done_cnt[1]++; done_cyc[1] = cyc; done_err[1] = bus.req1_err; order.push_back(1); end
                if (bus.PSEL != 4'b0) psel_hi++;
                if (bus.PENABLE)      pen_hi++;
            end
            chk("PSEL",       bus.PSEL,       ep);
            chk("PENABLE",    bus.PENABLE,    een);
            chk("req0_done",  bus.req0_done,  d0);
            chk("req1_done",  bus.req1_done,  d1);
            chk("req0_err",   bus.req0_err,   e0);
            chk("req1_err",   bus.req1_err,   e1);
            chk("req0_rdata", bus.req0_rdata, r0);
            chk("req1_rdata", bus.req1_rdata, r1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int p, input logic [31:0] a, input logic w,
                         input logic [31:0] d, output int start);
        @(posedge PCLK); #1;
        if (p == 0) begin
            bus.req0_addr = a; bus.req0_write = w; bus.req0_wdata = d; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_addr = a; bus.req1_write = w; bus.req1_wdata = d; bus.req1_valid = 1'b1;
        end
        start = cyc;
    endtask

    task automatic wait_done(input int p, input int budget);
        int n0;
        bit got;
        n0  = done_cnt[p];
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge PCLK); #2;
            if (done_cnt[p] != n0) got = 1;
        end
        if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL wait_done%0d: got no done expected done within %0d cycles", p, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        int st, dcnt;
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_write = 0; bus.req0_wdata = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_write = 0; bus.req1_wdata = '0;
        s_wait = '{0, 1, 2, 1000};
        s_data = '{32'h1111_0000, 32'h0000_000A, 32'h2222_0002, 32'h3333_3333};
        model_reset();
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;

        // Both requesters held: req0 write slave 0, req1 read slave 2
        @(posedge PCLK); #1;
        bus.req0_addr = 32'h1000_0000; bus.req0_write = 1; bus.req0_wdata = 32'hDEAD_BEEF;
        bus.req1_addr = 32'h1000_2008; bus.req1_write = 0; bus.req1_wdata = 32'h0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        order.delete();
        for (int i = 0; i < 80 && order.size() < 4; i++) begin
            @(posedge PCLK); #2;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", order[i], i % 2);
        chk("rr_rdata1", bus.req1_rdata, 32'h2222_0002);

        // Single read, slave 1 with one wait state
        psel_hi = 0; pen_hi = 0;
        issue(0, 32'h1000_1004, 1'b0, 32'h0, st);
        wait_done(0, 40);
        chk("t1_latency", done_cyc[0] - st, 4);
        chk("t1_err",     done_err[0], 1'b0);
        chk("t1_rdata",   bus.req0_rdata, 32'h0000_000A);
        chk("t1_psel",    psel_hi, 3);
        chk("t1_pen",     pen_hi, 2);

        // Decode errors: wrong BASE_HI, then nonzero addr[15:14]
        psel_hi = 0;
        issue(1, 32'h2000_0000, 1'b0, 32'h0, st);
        wait_done(1, 20);
        chk("dec_latency", done_cyc[1] - st, 1);
        chk("dec_err",     done_err[1], 1'b1);
        chk("dec_rdata1",  bus.req1_rdata, 32'h2222_0002);
        chk("dec_psel",    psel_hi, 0);
        issue(0, 32'h1000_4000, 1'b0, 32'h0, st);
        wait_done(0, 20);
        chk("dec2_err", done_err[0], 1'b1);

        // Timeout on slave 3, then a normal write
        issue(0, 32'h1000_3000, 1'b0, 32'h0, st);
        wait_done(0, 60);
        chk("tmo_latency", done_cyc[0] - st, TMO + 2);
        chk("tmo_err",     done_err[0], 1'b1);
        chk("tmo_rdata0",  bus.req0_rdata, 32'h0000_000A);
        issue(0, 32'h1000_0010, 1'b1, 32'h1234_5678, st);
        wait_done(0, 40);
        chk("post_tmo_latency", done_cyc[0] - st, 3);
        chk("post_tmo_err",     done_err[0], 1'b0);

        // Slave 0 PREADY toggling during slave 2 accesses
        s_data[2] = 32'h2222_0055;
        noise_en  = 1'b1;
        issue(1, 32'h1000_2000, 1'b0, 32'h0, st);
        wait_done(1, 40);
        chk("noise_latency", done_cyc[1] - st, 5);
        chk("noise_rdata1",  bus.req1_rdata, 32'h2222_0055);
        issue(1, 32'h1000_2004, 1'b1, 32'hCAFE_0001, st);
        wait_done(1, 40);
        chk("wr_keeps_rdata1", bus.req1_rdata, 32'h2222_0055);
        noise_en  = 1'b0;

        // Reset during ACCESS, then a fresh transfer
        issue(0, 32'h1000_3000, 1'b0, 32'h0, st);
        for (int i = 0; i < 10 && !bus.PENABLE; i++) begin
            @(posedge PCLK); #1;
        end
        chk("rst_in_access", bus.PENABLE, 1'b1);
        dcnt = done_cnt[0];
        PRESET = 1'b0;
        bus.req0_valid = 1'b0;
        #1;
        chk("rst_psel_now", bus.PSEL, 4'b0000);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b1;
        chk("rst_no_done", done_cnt[0], dcnt);
        issue(1, 32'h1000_1000, 1'b0, 32'h0, st);
        wait_done(1, 40);
        chk("post_rst_latency", done_cyc[1] - st, 4);
        chk("post_rst_rdata1",  bus.req1_rdata, 32'h0000_000A);
        chk("post_rst_rdata0",  bus.req0_rdata, 32'h0000_0000);

        repeat (3) @(posedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
